// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+1 cycle latency from the start edge to the registered result.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_wr
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept, last_iter;

  // Operand capture decode (combinational view of the incoming request)
  logic            in_div, in_a_signed, in_b_signed, in_sa, in_sb;
  logic [XLEN-1:0] in_a_abs, in_b_abs;

  // Latched operation context
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            sa_q, sb_q, b_zero_q;
  logic [XLEN-1:0] a_abs_q, b_abs_q;
  logic [XLEN-1:0] hi_q, lo_q;

  // Iteration and sign-correction results
  logic [XLEN-1:0]   hi_step, lo_step;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, sign_res;

  assign accept    = (state_q == IDLE || state_q == DONE) && start && !kill;
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  // MUL/MULH/MULHSU treat op_a as signed, MUL/MULH treat op_b as signed;
  // DIV/REM (funct3[0]=0) are signed on both operands.
  assign in_div      = funct3[2];
  assign in_a_signed = in_div ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign in_b_signed = in_div ? !funct3[0] : !funct3[1];
  assign in_sa       = in_a_signed && op_a[XLEN-1];
  assign in_sb       = in_b_signed && op_b[XLEN-1];
  assign in_a_abs    = in_sa ? -op_a : op_a;
  assign in_b_abs    = in_sb ? -op_b : op_b;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (kill) state_d = IDLE;
            else if (last_iter) state_d = SIGN;
      SIGN: state_d = kill ? IDLE : DONE;
      DONE: state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One radix-2 step: multiply shifts {hi,lo} right adding |a| on lo[0];
  // divide shifts the dividend bit into the partial remainder and keeps the
  // difference when it does not borrow. A zero divisor yields all-ones quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({1'b0, a_abs_q} & {(XLEN+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_abs_q};
    if (f3_q[2]) begin
      hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], !div_diff[XLEN]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection for the SIGN state
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_s  = sa_q ? -hi_q : hi_q;
    case (f3_q)
      3'b000:                 sign_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sign_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sign_res = b_zero_q ? '1 : quo_s;
      default:                sign_res = rem_s;
    endcase
  end

  // Control state, iteration counter and architecturally visible outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= '0;
      else if (state_q == CALC) cnt_q <= cnt_q + 1'b1;
      if (state_q == SIGN && !kill) begin
        result <= sign_res;
        rd_out <= rd_q;
      end
    end
  end

  // Datapath registers: operands latched at accept, iterated in CALC
  // NOTE: no reset here; every field is written at accept before it is read,
  // so resetting it would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q     <= funct3;
      rd_q     <= rd_in;
      sa_q     <= in_sa;
      sb_q     <= in_sb;
      b_zero_q <= (op_b == '0);
      a_abs_q  <= in_a_abs;
      b_abs_q  <= in_b_abs;
      hi_q     <= '0;
      lo_q     <= in_div ? in_a_abs : in_b_abs;
    end else if (state_q == CALC) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == SIGN);
  assign done   = (state_q == DONE);
  assign reg_wr = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control corner
// cases (ignored start, kill, back-to-back, mid-op reset) and random ops.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, reg_wr;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on plain 64-bit / signed SV arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a request for one edge (caller is always #1 after a posedge);
  // optionally record the expected outcome. Operands are scrambled afterwards.
  task automatic do_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input bit expect_it);
    exp_t e;
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    if (expect_it) begin
      e.res = exp_res;
      e.rd  = rd;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
  endtask

  // Bounded wait for done; checks latency and the scoreboard head
  task automatic wait_done(input string tag, input int lat);
    int   n = 0;
    exp_t e;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    if (done) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({tag, " result"}, result, e.res);
        check({tag, " rd_out"}, 32'(rd_out), 32'(e.rd));
        check({tag, " reg_wr"}, 32'(reg_wr), 32'(e.rd != 5'd0));
        last_res = e.res;
        last_rd  = e.rd;
      end else begin
        check({tag, " unexpected done"}, 32'(sb_q.size()), 32'd1);
      end
    end
  endtask

  // Watch for a number of cycles and require that done never appears
  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check({tag, " done count"}, 32'(seen), 32'd0);
  endtask

  logic [2:0]  d_f3 [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
  logic [31:0] d_a  [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                             32'h8000_0000, 32'd3};
  logic [31:0] d_b  [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
  logic [4:0]  d_rd [13] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                             5'd11, 5'd12, 5'd0};
  logic [31:0] d_ex [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                             32'd5, 32'h8000_0000, 32'd0, 32'd12};

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst reg_wr", 32'(reg_wr), 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases including divide-by-zero, overflow and rd=0
    for (int i = 0; i < 13; i++) begin
      do_start(d_f3[i], d_a[i], d_b[i], d_rd[i], d_ex[i], 1'b1);
      wait_done($sformatf("dir%0d", i), 33);
      @(posedge clk); #1;
      check($sformatf("dir%0d pulse", i), 32'(done), 32'd0);
    end

    // Start while busy is ignored; only the first result returns
    do_start(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign busy", 32'(busy), 32'd1);
    wait_done("ign", 23);

    // Kill mid-CALC: no done, busy drops, result and rd_out unchanged
    do_start(3'd5, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    expect_quiet("kill", 40);
    check("kill result", result, last_res);
    check("kill rd_out", 32'(rd_out), 32'(last_rd));

    // Back-to-back: start issued in the DONE cycle
    do_start(3'd5, 32'd100, 32'd7, 5'd13, 32'd14, 1'b1);
    wait_done("b2b0", 33);
    do_start(3'd7, 32'd100, 32'd7, 5'd14, 32'd2, 1'b1);
    check("b2b busy", 32'(busy), 32'd1);
    wait_done("b2b1", 33);

    // Reset asserted mid-CALC
    @(posedge clk); #1;
    do_start(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 32'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("mrst result", result, 32'd0);
    check("mrst rd_out", 32'(rd_out), 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_quiet("mrst", 40);

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) rb = rb & 32'h0000_00FF;
      do_start(rf3, ra, rb, 5'(i + 1), model(rf3, ra, rb), 1'b1);
      wait_done($sformatf("rnd%0d", i), 33);
    end

    check("sb empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
